smul_acc_drain: RTL

// - Consumer of the packed 64-bit product word res_mac_next from the SubMAC multiplier.
// - Splits the word into lanes by precision and accumulates signed lane sums over a programmed run length.
// - Hands the packed per-lane result to the result path with a valid/ready handshake.
// - Sits between the SubMAC multiplier and the MAC result buffer.

---
 rtl/smul_acc_drain_if.sv | 21 ++
 rtl/smul_acc_drain.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/smul_acc_drain_if.sv
// Stream bundle between the SubMAC product feed and the MAC result buffer.
// The DUT takes the slave view; the feeder/consumer side takes the master view.
interface smul_acc_drain_if;
    logic [63:0] res_mac_next;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] acc_out;
    logic        acc_valid;
    logic        acc_ready;
    logic [7:0]  acc_ovf;

    modport slave (
        input  res_mac_next, res_valid, acc_ready,
        output res_ready, acc_out, acc_valid, acc_ovf
    );

    modport master (
        output res_mac_next, res_valid, acc_ready,
        input  res_ready, acc_out, acc_valid, acc_ovf
    );
endinterface

// File: rtl/smul_acc_drain.sv
// Splits SubMAC product words into INT8/16/32/64 lanes and accumulates them over a run.
// Macro SMUL_ACC_SATURATE_EN: clamp out-of-range lanes on output; otherwise wrap to lane width.
module smul_acc_drain #(
    parameter int ACC_GUARD = 8,
    parameter int CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_sclr,
    input  logic             i_ce,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_acc_len,
    input  logic [3:0]       i_select_precision,
    output logic             o_busy,
    output logic             o_cfg_err,
    smul_acc_drain_if.slave  bus
);
    // Every lane uses a slot sized for the widest (INT64) lane; one extra bit catches guard carry-out.
    localparam int AW = 64 + ACC_GUARD;
    localparam int SW = AW + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;
    state_t r_state, w_next;

    logic [3:0]           r_prec;
    logic [CNT_W-1:0]     r_len;
    logic [CNT_W-1:0]     r_cnt;
    logic signed [AW-1:0] r_acc [8];
    logic [7:0]           r_ovf;
    logic                 r_cfg_err;

    logic                 w_onehot, w_start_ok, w_start_bad, w_beat, w_last;
    logic [6:0]           w_lw;
    logic [3:0]           w_nl;
    logic signed [SW-1:0] w_lane [8];
    logic signed [SW-1:0] w_sum  [8];
    logic signed [SW-1:0] w_wrap [8];
    logic signed [SW-1:0] w_nar  [8];
    logic signed [SW-1:0] w_max;
    logic [7:0]           w_lovf;
    logic [63:0]          w_mask, w_acc_out;

    // Sign-extend the low w bits of v to the full internal width.
    function automatic logic signed [SW-1:0] sext(input logic [SW-1:0] v, input int w);
        int sh;
        sh = SW - w;
        return $signed(v << sh) >>> sh;
    endfunction

    assign w_onehot    = (i_select_precision != 4'd0) &&
                         ((i_select_precision & (i_select_precision - 4'd1)) == 4'd0);
    assign w_start_ok  = (r_state == IDLE) && i_start && (i_acc_len != '0) && w_onehot;
    assign w_start_bad = (r_state == IDLE) && i_start && !w_start_ok;
    assign w_beat      = bus.res_valid && bus.res_ready;
    assign w_last      = w_beat && ((r_cnt + CNT_W'(1)) == r_len);

    always_comb begin
        case (r_prec)
            4'b0001: begin w_lw = 7'd8;  w_nl = 4'd8; end
            4'b0010: begin w_lw = 7'd16; w_nl = 4'd4; end
            4'b0100: begin w_lw = 7'd32; w_nl = 4'd2; end
            default: begin w_lw = 7'd64; w_nl = 4'd1; end
        endcase
    end

    // Lane sum wraps at LW+ACC_GUARD bits; a flag is raised on guard wrap or LW-range exit.
    always_comb begin
        w_lovf = '0;
        for (int k = 0; k < 8; k++) begin
            w_lane[k] = sext(SW'(bus.res_mac_next >> (k * w_lw)), w_lw);
            w_sum[k]  = SW'(r_acc[k]) + w_lane[k];
            w_wrap[k] = sext(w_sum[k], w_lw + ACC_GUARD);
            w_lovf[k] = (w_wrap[k] != w_sum[k]) || (w_wrap[k] != sext(w_wrap[k], w_lw));
        end
    end

    always_comb begin
        w_acc_out = '0;
        w_mask    = (w_lw == 7'd64) ? '1 : ((64'd1 << w_lw) - 64'd1);
        w_max     = (SW'(1) << (w_lw - 7'd1)) - SW'(1);
        for (int k = 0; k < 8; k++) begin
            w_nar[k] = SW'(r_acc[k]);
`ifdef SMUL_ACC_SATURATE_EN
            if (w_nar[k] != sext(w_nar[k], w_lw))
                w_nar[k] = w_nar[k][SW-1] ? ~w_max : w_max;
`endif
            if (k < int'(w_nl))
                w_acc_out = w_acc_out | ((w_nar[k][63:0] & w_mask) << (k * w_lw));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_sclr)
            r_state <= IDLE;
        else if (i_ce)
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start_ok)    w_next = ACCUM;
            ACCUM:   if (w_last)        w_next = DRAIN;
            DRAIN:   if (bus.acc_ready) w_next = IDLE;
            default:                    w_next = IDLE;
        endcase
    end

    always_comb begin
        o_busy        = (r_state != IDLE);
        bus.res_ready = (r_state == ACCUM) && i_ce;
        bus.acc_valid = (r_state == DRAIN);
    end

    always_ff @(posedge i_clk) begin
        if (i_sclr) begin
            r_prec    <= 4'b0001;
            r_len     <= '0;
            r_cnt     <= '0;
            r_ovf     <= '0;
            r_cfg_err <= 1'b0;
            for (int k = 0; k < 8; k++) r_acc[k] <= '0;
        end else if (i_ce) begin
            r_cfg_err <= w_start_bad;
            if (w_start_ok) begin
                r_prec <= i_select_precision;
                r_len  <= i_acc_len;
                r_cnt  <= '0;
                r_ovf  <= '0;
                for (int k = 0; k < 8; k++) r_acc[k] <= '0;
            end else if (w_beat) begin
                r_cnt <= r_cnt + CNT_W'(1);
                for (int k = 0; k < 8; k++) begin
                    if (k < int'(w_nl)) begin
                        r_acc[k] <= w_wrap[k][AW-1:0];
                        r_ovf[k] <= r_ovf[k] | w_lovf[k];
                    end
                end
            end
        end
    end

    assign o_cfg_err   = r_cfg_err;
    assign bus.acc_out = w_acc_out;
    assign bus.acc_ovf = r_ovf;
endmodule
